// File: rtl/output_serializer.sv
// output_serializer: small block FIFO feeding a word shifter that streams each
// cipher block out as BLOCK_W/OUT_W words over a valid/ready handshake.
module output_serializer #(
   parameter int BLOCK_W   = 128,
   parameter int OUT_W     = 8,
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               in_valid,
   input  logic [BLOCK_W-1:0] in_block,
   output logic               in_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               block_done,
   output logic               busy,
   output logic               overflow
);
   localparam int WORDS = BLOCK_W / OUT_W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [BLOCK_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [BLOCK_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               block_done_q, block_done_d;
   logic               overflow_q, overflow_d;

   logic               push_s;
   logic               pop_s;
   logic               accept_s;
   logic               last_s;
   logic               fifo_empty_s;
   logic [OUT_W-1:0]   head_word_s;
   logic [BLOCK_W-1:0] shift_adv_s;

   // Word ordering: the head word always sits at one end of the shifter and
   // the shifter moves one word towards it per accepted word.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign head_word_s = shift_q[BLOCK_W-1 -: OUT_W];
         assign shift_adv_s = shift_q << OUT_W;
      end else begin : g_lsb_first
         assign head_word_s = shift_q[OUT_W-1:0];
         assign shift_adv_s = shift_q >> OUT_W;
      end
   endgenerate

   // Space is judged on the registered count only, so a same-cycle pop never
   // frees room for that cycle's write.
   assign in_ready     = (count_q != FULL_CNT);
   assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
   assign push_s       = in_valid & in_ready;
   assign accept_s     = (state_q == ST_SEND) & out_ready;
   assign last_s       = accept_s & (idx_q == LAST_IDX);

   assign out_valid  = (state_q == ST_SEND);
   assign out_data   = out_valid ? head_word_s : {OUT_W{1'b0}};
   assign block_done = block_done_q;
   assign overflow   = overflow_q;
   assign busy       = ~fifo_empty_s | (state_q == ST_SEND);

   // Serializer FSM: decides when to pop a block and advances the shifter.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      pop_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (last_s) begin
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (pop_s) begin
         shift_d = mem_q[rd_ptr_q];
         idx_d   = {IDX_W{1'b0}};
      end else if (accept_s) begin
         shift_d = shift_adv_s;
         idx_d   = idx_q + IDX_W'(1);
      end else begin
         shift_d = shift_q;
         idx_d   = idx_q;
      end
   end

   // FIFO bookkeeping: pointer wrap, occupancy and sticky drop flag.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      block_done_d = last_s;
      overflow_d   = overflow_q | (in_valid & ~in_ready);
      if (push_s) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Block storage; contents are meaningless until counted, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= in_block;
      end
   end

   // State registers; asynchronous reset discards any partial block.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         shift_q      <= {BLOCK_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         block_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         block_done_q <= block_done_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_output_serializer.sv
// tb_output_serializer: two instances (8-bit MSB-first, 32-bit LSB-first)
// share one stimulus stream and are compared each cycle to a queue model.
module tb_output_serializer;
   localparam logic [127:0] KAT = 128'h00112233445566778899AABBCCDDEEFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_;
   logic         in_valid;
   logic [127:0] in_block;
   logic         out_ready;

   logic         in_ready0, out_valid0, block_done0, busy0, overflow0;
   logic [7:0]   out_data0;
   logic         in_ready1, out_valid1, block_done1, busy1, overflow1;
   logic [31:0]  out_data1;

   output_serializer #(.BLOCK_W(128), .OUT_W(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_block(in_block),
      .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
      .out_ready(out_ready), .block_done(block_done0), .busy(busy0),
      .overflow(overflow0));

   output_serializer #(.BLOCK_W(128), .OUT_W(32), .DEPTH(2), .MSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_block(in_block),
      .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
      .out_ready(out_ready), .block_done(block_done1), .busy(busy1),
      .overflow(overflow1));

   int n_checks = 0;
   int n_errors = 0;
   int done_seen0 = 0;
   int accepts_seen0 = 0;

   // Reference model: per instance a queue of stored blocks plus the block
   // being sent and how many of its words have been accepted.
   logic [127:0] fq0[$];
   logic [127:0] fq1[$];
   logic [127:0] m_blk [2];
   int           m_sent [2];
   bit           m_active [2];
   bit           m_done [2];
   bit           m_ovf [2];

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int words_of(input int k);
      return (k == 0) ? 16 : 4;
   endfunction

   function automatic int fsize(input int k);
      return (k == 0) ? fq0.size() : fq1.size();
   endfunction

   task automatic fq_pop(input int k, output logic [127:0] b);
      if (k == 0) b = fq0.pop_front();
      else        b = fq1.pop_front();
   endtask

   task automatic fq_push(input int k, input logic [127:0] b);
      if (k == 0) fq0.push_back(b);
      else        fq1.push_back(b);
   endtask

   // Word n of a block: instance 0 counts bytes from the top, instance 1
   // counts 32-bit words from the bottom.
   function automatic logic [63:0] exp_word(input int k, input logic [127:0] blk, input int n);
      int           w;
      logic [127:0] t;
      logic [127:0] mask;
      w = (k == 0) ? 8 : 32;
      if (k == 0) t = blk >> (128 - (n + 1) * w);
      else        t = blk >> (n * w);
      mask = (128'd1 << w) - 128'd1;
      t = t & mask;
      return t[63:0];
   endfunction

   task automatic model_reset();
      fq0.delete();
      fq1.delete();
      for (int k = 0; k < 2; k++) begin
         m_blk[k] = 128'd0; m_sent[k] = 0; m_active[k] = 1'b0;
         m_done[k] = 1'b0; m_ovf[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int           sz;
         bit           ready, acc, last, grab;
         logic [127:0] b;
         sz    = fsize(k);
         ready = (sz != 2);
         acc   = m_active[k] && out_ready;
         last  = acc && (m_sent[k] == words_of(k) - 1);
         grab  = !m_active[k] || last;
         m_done[k] = last;
         if (acc) m_sent[k]++;
         if (grab) begin
            if (sz > 0) begin
               fq_pop(k, b);
               m_blk[k] = b; m_sent[k] = 0; m_active[k] = 1'b1;
            end else begin
               m_active[k] = 1'b0;
            end
         end
         if (in_valid && ready)  fq_push(k, in_block);
         if (in_valid && !ready) m_ovf[k] = 1'b1;
      end
   endtask

   task automatic check_outputs();
      logic [63:0] ew0, ew1;
      ew0 = m_active[0] ? exp_word(0, m_blk[0], m_sent[0]) : 64'd0;
      ew1 = m_active[1] ? exp_word(1, m_blk[1], m_sent[1]) : 64'd0;
      check_val("i0_out_valid",  128'(out_valid0),  128'(m_active[0]));
      check_val("i0_out_data",   128'(out_data0),   128'(ew0));
      check_val("i0_in_ready",   128'(in_ready0),   128'(fsize(0) != 2));
      check_val("i0_block_done", 128'(block_done0), 128'(m_done[0]));
      check_val("i0_busy",       128'(busy0),       128'(fsize(0) != 0 || m_active[0]));
      check_val("i0_overflow",   128'(overflow0),   128'(m_ovf[0]));
      check_val("i1_out_valid",  128'(out_valid1),  128'(m_active[1]));
      check_val("i1_out_data",   128'(out_data1),   128'(ew1));
      check_val("i1_in_ready",   128'(in_ready1),   128'(fsize(1) != 2));
      check_val("i1_block_done", 128'(block_done1), 128'(m_done[1]));
      check_val("i1_busy",       128'(busy1),       128'(fsize(1) != 0 || m_active[1]));
      check_val("i1_overflow",   128'(overflow1),   128'(m_ovf[1]));
      if (block_done0) done_seen0++;
      if (out_valid0 && out_ready) accepts_seen0++;
   endtask

   // One clock: check outputs against the model, take the edge, advance model.
   task automatic tick();
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Asynchronous reset from a negedge; outputs must clear at once and
   // writes presented during reset must be ignored.
   task automatic apply_reset();
      rst_ = 1'b0;
      #1;
      model_reset();
      check_outputs();
      in_valid = 1'b1;
      in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst_     = 1'b1;
   endtask

   initial begin
      rst_      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_block  = 128'd0;
      model_reset();
      @(negedge clk);
      apply_reset();

      // single block, no backpressure
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_block  = KAT;
      tick();
      in_valid  = 1'b0;
      repeat (24) tick();

      // backpressure pattern 1,0,0,1
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         out_ready = ((i % 4) == 0) || ((i % 4) == 3);
         tick();
      end

      // back-to-back blocks
      done_seen0 = 0;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_block   = KAT;
      tick();
      in_block   = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      in_valid   = 1'b0;
      repeat (40) tick();
      check_val("b2b_done_count", 128'(done_seen0), 128'd2);

      // overflow: four writes with the output stalled
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      check_val("ovf_sticky", 128'(overflow0), 128'd1);
      out_ready = 1'b1;
      repeat (60) tick();

      // reset mid-stream after word 5
      accepts_seen0 = 0;
      in_valid = 1'b1;
      in_block = KAT;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && accepts_seen0 < 5; i++) tick();
      check_val("mid_words_before_reset", 128'(accepts_seen0), 128'd5);
      apply_reset();
      repeat (6) tick();

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) == 0);
         in_block  = {$urandom(), $urandom(), $urandom(), $urandom()};
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 599) == 0) begin
            apply_reset();
         end else begin
            tick();
         end
      end
      in_valid = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
